// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the SDRAM controller command port: high-priority read bursts,
// single-word writes with starvation protection. Optional watchdog enabled by `define ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int AW             = 25,
    parameter int DW             = 16,
    parameter int BURST_LEN      = 256,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          mem_clk,
    input  logic          rst_n,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_data_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          sdr_idle,
    input  logic          sdr_ack,
    input  logic          sdr_data_next,
    input  logic [DW-1:0] sdr_rdata,
    output logic          sdr_req,
    output logic          sdr_wr,
    output logic [AW-1:0] sdr_addr,
    output logic [DW-1:0] sdr_wdata,
    output logic          owner,
    output logic          busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic          err_timeout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RD_DATA = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [8:0] BEAT_LAST  = 9'(BURST_LEN - 1);

    if (BURST_LEN < 1 || BURST_LEN > 256 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("mem_arbiter: parameter out of range");
    end

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            owner_q, owner_d;
    logic [3:0]      starve_q, starve_d;
    logic [8:0]      beat_q, beat_d;
    logic            sel_wr;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]     wd_q, wd_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        beat_d   = beat_q;
        sel_wr   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wd_d     = '0;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sdr_idle && (rd_req || wr_req)) begin
                    sel_wr  = wr_req && (!rd_req || starve_q == STARVE_MAX);
                    state_d = S_ISSUE;
                    req_d   = 1'b1;
                    wr_d    = sel_wr;
                    owner_d = sel_wr;
                    addr_d  = sel_wr ? wr_addr : rd_addr;
                    if (sel_wr) begin
                        wdata_d = wr_data;
                    end
                    // Only reads that bypass a waiting writer count towards forcing a write.
                    if (sel_wr || !wr_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (sdr_ack) begin
                    req_d = 1'b0;
                    if (owner_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD_DATA;
                        beat_d  = '0;
                    end
                end
            end
            S_RD_DATA: begin
                if (sdr_data_next) begin
                    beat_d = beat_q + 9'd1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
`ifdef ARB_TIMEOUT_EN
        // A stalled command or burst is abandoned; the requester simply asks again.
        if (state_q != S_IDLE && state_d == state_q && !sdr_data_next) begin
            if (wd_q == WD_LAST) begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= 1'b0;
            starve_q <= '0;
            beat_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            beat_q   <= beat_d;
`ifdef ARB_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

    // Acks are combinational so the writer can drop its request on the ack edge.
    assign rd_ack        = rst_n && (state_q == S_ISSUE) && sdr_ack && !owner_q;
    assign wr_ack        = rst_n && (state_q == S_ISSUE) && sdr_ack && owner_q;
    assign rd_data_valid = rst_n && (state_q == S_RD_DATA) && sdr_data_next;
    assign rd_data       = sdr_rdata;
    assign sdr_req       = req_q;
    assign sdr_wr        = wr_q;
    assign sdr_addr      = addr_q;
    assign sdr_wdata     = wdata_q;
    assign owner         = owner_q;
    assign busy          = (state_q != S_IDLE);
`ifdef ARB_TIMEOUT_EN
    assign err_timeout   = err_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single SDRAM controller command port between two requesters, both in the mem_clk domain.
- Requester RD is the display refresh reader: burst reads, high priority.
- Requester WR is the FTDI pixel writer: single-word writes using the req-held-until-ack handshake.
- Sits between the requesters and the SDRAM controller. Handles grant selection, command sequencing, read-burst data steering and write starvation protection.

Parameters:
- AW, 25, memory word address width.
- DW, 16, data word width.
- BURST_LEN, 256, words returned per read command (range 1..256).
- STARVE_LIMIT, 4, consecutive read grants allowed while wr_req is pending before a write is forced (range 1..15).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- mem_clk  in  1  memory clock; only clock of the block.
- rst_n  in  1  synchronous active-low reset.
- rd_req  in  1  read burst request; held high until rd_ack.
- rd_addr  in  AW  burst start address; stable while rd_req is high.
- rd_ack  out  1  one-cycle pulse: read command accepted.
- rd_data_valid  out  1  one word of read data is valid this cycle.
- rd_data  out  DW  read data word.
- wr_req  in  1  write request; held high until wr_ack.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_ack  out  1  one-cycle pulse: write accepted.
- sdr_idle  in  1  controller ready for a new command.
- sdr_ack  in  1  controller accepted the presented command.
- sdr_data_next  in  1  one read word is present on sdr_rdata.
- sdr_rdata  in  DW  controller read data.
- sdr_req  out  1  command request.
- sdr_wr  out  1  1 = write, 0 = read.
- sdr_addr  out  AW  command address.
- sdr_wdata  out  DW  write data.
- owner  out  1  current or last grant: 0 = RD, 1 = WR.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n low at a rising mem_clk edge, in any state):
  - state goes to IDLE.
  - sdr_req, sdr_wr, sdr_addr, sdr_wdata, owner, starve_cnt, beat_cnt all 0.
  - rd_ack, wr_ack, rd_data_valid are 0 while in reset.
  - No pending command survives reset. An abandoned read burst is simply not tracked; the controller is reset alongside.
- States: IDLE, ISSUE, RD_DATA.
- IDLE: when sdr_idle = 1 and any request is high, select and latch the grant.
  - Select WR if wr_req & (~rd_req | starve_cnt == STARVE_LIMIT); otherwise select RD.
  - Latch sdr_addr, sdr_wdata (WR only), sdr_wr and owner.
  - Set sdr_req = 1 on the next edge; go to ISSUE.
  - If sdr_idle = 0, wait in IDLE.
- ISSUE:
  - Hold sdr_req and the command fields stable until sdr_ack.
  - rd_ack = sdr_ack & ~owner and wr_ack = sdr_ack & owner, both combinational in ISSUE only. This gives zero-latency release, matching the writer, which drops its request on the ack edge.
  - On sdr_ack: sdr_req = 0 at the next edge. A write goes to IDLE; a read goes to RD_DATA with beat_cnt = 0.
- RD_DATA:
  - rd_data_valid = sdr_data_next and rd_data = sdr_rdata, both combinational pass-through.
  - beat_cnt increments on each sdr_data_next (9-bit counter).
  - On the beat where beat_cnt == BURST_LEN-1 together with sdr_data_next, go to IDLE.
  - No new grant is made until the burst completes. Writes wait.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each RD grant made while wr_req is high.
  - starve_cnt clears on a WR grant, or on an RD grant made with wr_req low.
- Back-to-back: the earliest new grant is in the IDLE cycle after return. Minimum write cadence is 3 cycles (IDLE, ISSUE with same-cycle ack, IDLE).
- sdr_data_next outside RD_DATA is ignored: rd_data_valid = 0.
- Requests that drop before ack are a protocol violation; the latched command is still completed.
- busy = (state != IDLE). owner persists after return to IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles spent in ISSUE or RD_DATA and clears on each state change or sdr_data_next.
  - When the count reaches TIMEOUT_CYCLES: force sdr_req = 0, go to IDLE, and set a sticky output err_timeout (1 bit, cleared only by rst_n).
  - A timed-out requester receives no ack and re-requests normally.
- Undefined: no watchdog and no err_timeout port. The arbiter waits indefinitely.

Test Plan:
- Single write: wr_req with addr 0x10, data 0x1234; sdr_idle = 1, sdr_ack on 2nd ISSUE cycle -> sdr_wr = 1, sdr_addr 0x10, sdr_wdata 0x1234, wr_ack exactly one pulse coincident with sdr_ack, then IDLE.
- Read burst BURST_LEN = 4: rd_req addr 0x200, then 4 sdr_data_next pulses with data 1,2,3,4 -> rd_ack once, rd_data_valid 4 pulses with matching data, busy falls after 4th beat.
- Simultaneous: rd_req and wr_req both held continuously, STARVE_LIMIT = 4 -> grant sequence RD, RD, RD, RD, WR, RD, ...; wr_ack after 4 read bursts.
- sdr_idle = 0 with requests pending for 10 cycles -> sdr_req stays 0; grant occurs in the cycle after sdr_idle rises.
- Reset mid-burst: rst_n low after 2 of 4 beats -> next edge IDLE, sdr_req 0, starve_cnt 0; subsequent write completes normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16: sdr_ack never arrives -> after 16 cycles in ISSUE, sdr_req drops, err_timeout = 1 and stays high.
